// File: rtl/uart_rx_cfg_if.sv
// Serial-receive bus: pad input plus received word, status flags and busy.
// master = receiver side, slave = pad driver / word consumer side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 recv;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output data, recv, frame_err, parity_err, busy
  );

  modport slave (
    output rx,
    input  data, recv, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to vote each bit from three samples around its centre.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.master bus
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  // The decision waits one cycle so the window MID-2..MID is fully captured.
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_START = CW'(MID - 1 + OFS);
  localparam logic [3:0]    IDX_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    IDX_SLAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = 1'(PARITY == 2);
  localparam logic          HAS_PAR   = 1'(PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 recv_q, recv_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 bit_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev2_q <= 1'b1;
    else     rx_prev2_q <= rx_prev_q;
  end

  assign bit_s = (rx_sync_q & rx_prev_q) | (rx_sync_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  assign bit_s = rx_sync_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      recv_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      recv_q       <= recv_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_d       = data_q;
    recv_d       = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // Needs a high-to-low transition, so a held-low line never re-arms.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_START) begin
          cnt_d   = '0;
          state_d = bit_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_DLAST) begin
            idx_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ bit_s) != ODD_PAR;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~bit_s;
          if (idx_q == IDX_SLAST) begin
            idx_d        = '0;
            recv_d       = 1'b1;
            data_d       = shift_q;
            frame_err_d  = ferr_q | ~bit_s;
            parity_err_d = HAS_PAR & perr_q;
            state_d      = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.data       = data_q;
  assign bus.recv       = recv_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, even-parity and 2-stop-bit instances on one clock.
// Expected glitch result follows UART_RX_MAJORITY_EN.
module tb_uart_rx_cfg;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus2 ();

  assign bus0.rx = rx0;
  assign bus1.rx = rx1;
  assign bus2.rx = rx2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Received words as {frame_err, parity_err, data}
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always @(negedge clk) begin
    if (bus0.recv) begin
      q0.push_back({bus0.frame_err, bus0.parity_err, bus0.data});
      $display("recv ch0 data=%h frame_err=%b parity_err=%b", bus0.data, bus0.frame_err, bus0.parity_err);
    end
    if (bus1.recv) begin
      q1.push_back({bus1.frame_err, bus1.parity_err, bus1.data});
      $display("recv ch1 data=%h frame_err=%b parity_err=%b", bus1.data, bus1.frame_err, bus1.parity_err);
    end
    if (bus2.recv) begin
      q2.push_back({bus2.frame_err, bus2.parity_err, bus2.data});
      $display("recv ch2 data=%h frame_err=%b parity_err=%b", bus2.data, bus2.frame_err, bus2.parity_err);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Sends n bits LSB first; glitch_bit inverts one cycle at that bit's centre.
  task automatic send_bits(input int ch, input logic [15:0] bits, input int n, input int glitch_bit);
    for (int b = 0; b < n; b++) begin
      set_rx(ch, bits[b]);
      for (int c = 0; c < CPB; c++) begin
        if (b == glitch_bit && c == 4) set_rx(ch, ~bits[b]);
        if (b == glitch_bit && c == 5) set_rx(ch, bits[b]);
        tick(1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++; if (bus0.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus0.data); end
    n_checks++; if (bus0.recv !== 1'b0) begin n_fail++; $display("FAIL reset_recv: got %b expected 0", bus0.recv); end
    n_checks++; if (bus0.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", bus0.frame_err); end
    n_checks++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", bus0.parity_err); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
    n_checks++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_ch2: got %b expected 0", bus2.busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[3];
    logic [9:0] e;
    exp_b[0] = 8'h5C; exp_b[1] = 8'h5D; exp_b[2] = 8'h5E;
    q0.delete();
    for (int i = 0; i < 3; i++) send_bits(0, {6'b0, 1'b1, exp_b[i], 1'b0}, 10, -1);
    tick(4);
    n_checks++; if (q0.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", q0.size()); end
    for (int i = 0; i < 3; i++) begin
      e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
      n_checks++;
      if (e !== {2'b00, exp_b[i]}) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, e, {2'b00, exp_b[i]}); end
    end
  endtask

  task automatic test_parity;
    logic [9:0] e;
    q1.delete();
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1);
    tick(4);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
    tick(4);
    n_checks++; if (q1.size() != 2) begin n_fail++; $display("FAIL parity_count: got %0d expected 2", q1.size()); end
    e = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b01, 8'hA5}) begin n_fail++; $display("FAIL parity_bad: got %h expected %h", e, {2'b01, 8'hA5}); end
    e = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL parity_good: got %h expected %h", e, {2'b00, 8'h3C}); end
  endtask

  task automatic test_stop2_break;
    logic [9:0] e;
    q2.delete();
    send_bits(2, {5'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 11, -1);
    tick(40);
    n_checks++; if (q2.size() != 1) begin n_fail++; $display("FAIL stop2_count: got %0d expected 1", q2.size()); end
    e = (q2.size() > 0) ? q2.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b10, 8'h81}) begin n_fail++; $display("FAIL stop2_frame_err: got %h expected %h", e, {2'b10, 8'h81}); end
    n_checks++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b expected 0", bus2.busy); end
    rx2 = 1'b1;
    tick(16);
    n_checks++; if (q2.size() != 0) begin n_fail++; $display("FAIL break_spurious: got %0d words expected 0", q2.size()); end
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'h42, 1'b0}, 11, -1);
    tick(4);
    n_checks++; if (q2.size() != 1) begin n_fail++; $display("FAIL rearm_count: got %0d expected 1", q2.size()); end
    e = (q2.size() > 0) ? q2.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b00, 8'h42}) begin n_fail++; $display("FAIL rearm_word: got %h expected %h", e, {2'b00, 8'h42}); end
  endtask

  task automatic test_false_start;
    q0.delete();
    rx0 = 1'b0;
    tick(2);
    rx0 = 1'b1;
    tick(1);
    n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_hi: got %b expected 1", bus0.busy); end
    tick(10);
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_lo: got %b expected 0", bus0.busy); end
    n_checks++; if (q0.size() != 0) begin n_fail++; $display("FAIL false_start_recv: got %0d words expected 0", q0.size()); end
    n_checks++; if (bus0.data !== 8'h5E) begin n_fail++; $display("FAIL false_start_data: got %h expected 5e", bus0.data); end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] e;
    q0.delete();
    send_bits(0, {6'b0, 1'b1, 8'hF0, 1'b0}, 5, -1);
    rx0 = 1'b1;
    tick(3);
    n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", bus0.busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus0.data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", bus0.data); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus0.busy); end
    n_checks++; if (bus0.recv !== 1'b0) begin n_fail++; $display("FAIL midrst_recv: got %b expected 0", bus0.recv); end
    n_checks++; if ({bus0.frame_err, bus0.parity_err} !== 2'b00) begin n_fail++; $display("FAIL midrst_errs: got %b expected 00", {bus0.frame_err, bus0.parity_err}); end
    tick(2);
    rst = 1'b0;
    tick(20);
    n_checks++; if (q0.size() != 0) begin n_fail++; $display("FAIL midrst_no_recv: got %0d words expected 0", q0.size()); end
    send_bits(0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, -1);
    tick(4);
    n_checks++; if (q0.size() != 1) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 1", q0.size()); end
    e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b00, 8'h0F}) begin n_fail++; $display("FAIL post_rst_word: got %h expected %h", e, {2'b00, 8'h0F}); end
  endtask

  task automatic test_glitch;
    logic [9:0] e;
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h00;
`else
    exp_d = 8'h04;
`endif
    q0.delete();
    send_bits(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 3);
    tick(4);
    n_checks++; if (q0.size() != 1) begin n_fail++; $display("FAIL glitch_count: got %0d expected 1", q0.size()); end
    e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
    n_checks++; if (e !== {2'b00, exp_d}) begin n_fail++; $display("FAIL glitch_word: got %h expected %h", e, {2'b00, exp_d}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop2_break();
    test_false_start();
    test_reset_midframe();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
